// File: rtl/debug_uart_tx_pkg.sv
// Shared constants for the debug-port UART transmitter.
// FSM encoding, framing sizes and the default sync header byte.
package debug_uart_tx_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;

  localparam int BITS_PER_BYTE = 8;
  localparam int FRAME_BITS    = 10;

  localparam int FRAME_BYTES_BASE = 8;
  localparam int FRAME_BYTES_CSUM = 9;

  localparam int FRAME_LEN_BASE = FRAME_BITS * FRAME_BYTES_BASE;
  localparam int FRAME_LEN_CSUM = FRAME_BITS * FRAME_BYTES_CSUM;

  function automatic logic [7:0] xor_bytes(
    input logic [6:0][7:0] b
  );
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < 7; i++) begin
      x = x ^ b[i];
    end
    return x;
  endfunction

endpackage

// File: rtl/debug_uart_tx_uart_tx_byte.sv
// 8N1 byte serialiser; a start seen in the last stop-bit cycle
// chains the next byte with no idle gap.
module uart_tx_byte
  import debug_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       done,
  output logic       tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          wrap;

  assign wrap = (cnt == CNT_MAX);
  assign done = (state == ST_STOP) && wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      cnt <= (state == ST_IDLE || wrap) ? '0 : cnt + 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            shreg <= data;
            state <= ST_START;
            tx    <= 1'b0;
          end
        end
        ST_START: begin
          if (wrap) begin
            state   <= ST_DATA;
            bit_idx <= '0;
            tx      <= shreg[0];
          end
        end
        ST_DATA: begin
          if (wrap) begin
            if (bit_idx == LAST_BIT) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end
        end
        ST_STOP: begin
          if (wrap) begin
            if (start) begin
              shreg <= data;
              state <= ST_START;
              tx    <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/debug_uart_tx.sv
// Snapshots debug ports and sends them as one 8N1 frame.
// Define DEBUG_TX_CHECKSUM_EN to append an XOR checksum byte.
module debug_uart_tx
  import debug_uart_tx_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] HEADER_BYTE  = HEADER_BYTE_DEF
) (
  input  logic       clk_i,
  input  logic       nreset_i,
  input  logic [7:0] port1_i,
  input  logic [7:0] port2_i,
  input  logic [7:0] port3_i,
  input  logic [7:0] port4_i,
  input  logic [7:0] port5_i,
  input  logic [7:0] port6_i,
  input  logic [7:0] port7_i,
  input  logic       send_i,
  output logic       busy_o,
  output logic       frame_done_o,
  output logic       tx_o
);

`ifdef DEBUG_TX_CHECKSUM_EN
  localparam int NBYTES = FRAME_BYTES_CSUM;
`else
  localparam int NBYTES = FRAME_BYTES_BASE;
`endif
  localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

  logic [2:0]      state;
  logic [3:0]      byte_idx;
  logic [6:0][7:0] snap;
  logic            accept;
  logic            byte_done;
  logic            chain;
  logic            eng_start;
  logic [7:0]      eng_data;

  assign accept    = send_i && !busy_o;
  assign chain     = byte_done && (byte_idx != LAST_IDX);
  assign eng_start = accept || chain;

  // byte_idx names the byte now on the line; chain loads the next one
  always_comb begin
    eng_data = HEADER_BYTE;
    if (!accept) begin
      for (int i = 0; i < 7; i++) begin
        if (byte_idx == 4'(i)) eng_data = snap[i];
      end
`ifdef DEBUG_TX_CHECKSUM_EN
      if (byte_idx == 4'd7) eng_data = xor_bytes(snap);
`endif
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state        <= ST_IDLE;
      byte_idx     <= '0;
      snap         <= '0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (accept) begin
        snap     <= {port7_i, port6_i, port5_i, port4_i,
                     port3_i, port2_i, port1_i};
        byte_idx <= '0;
        busy_o   <= 1'b1;
        state    <= ST_DATA;
      end else if (state == ST_DATA && byte_done) begin
        if (byte_idx == LAST_IDX) begin
          byte_idx     <= '0;
          busy_o       <= 1'b0;
          frame_done_o <= 1'b1;
          state        <= ST_DONE;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end else if (state == ST_DONE) begin
        state <= ST_IDLE;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk   (clk_i),
    .rst_n (nreset_i),
    .start (eng_start),
    .data  (eng_data),
    .done  (byte_done),
    .tx    (tx_o)
  );

endmodule

// File: doc/debug_uart_tx.md
Name: debug_uart_tx

Overview:
Reader/transmitter end of the CPU debug-port interface. It snapshots the seven 8-bit debug ports on request and serialises them as one framed 8N1 UART packet to the host serial debugger. It sits at the top level beside cpu, consuming debug_port1..7 and driving the board TX pin.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal minimum 2
HEADER_BYTE, 8'hA5, sync byte sent first in every frame

Ports:
clk_i  in  1  system clock
nreset_i  in  1  asynchronous active-low reset
port1_i .. port7_i  in  8 each  debug bytes from cpu (debug_port1..7)
send_i  in  1  frame request; level sampled each posedge
busy_o  out  1  high while a frame is in flight
frame_done_o  out  1  one-cycle pulse when the last stop bit completes
tx_o  out  1  UART line, idle high

Behaviour:
- Reset (async, nreset_i low): tx_o=1, busy_o=0, frame_done_o=0, state IDLE, counters and snapshot cleared. Reset mid-frame aborts immediately; tx_o returns high with no partial byte completed.
- Accept: at any posedge with busy_o=0 and send_i=1, latch port1_i..port7_i into an 8-byte shadow {HEADER_BYTE, p1..p7}. busy_o=1 and tx_o=0 (start bit of byte 0) from the next cycle. Port changes after the accept edge do not affect the frame.
- send_i while busy_o=1 is ignored, not queued.
- Frame order: HEADER_BYTE, then p1, p2, ... p7. Each byte is 10 bits: start(0), d0..d7 LSB first, stop(1). Each bit is held exactly CLKS_PER_BIT cycles. A frame lasts 80*CLKS_PER_BIT cycles. There are no idle gaps between bytes.
- FSM: IDLE -> START -> DATA (8 bits, bit index 0..7) -> STOP -> START of the next byte if byte index < last, else DONE -> IDLE.
  - DONE lasts one cycle: frame_done_o=1, busy_o=0, tx_o=1.
  - A send_i seen in the DONE cycle is accepted, giving back-to-back frames with a one-cycle idle-high gap.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. A bit advance happens only on wrap. The counter resets to 0 on every state entry from IDLE.
- Byte index: 0..7, or 0..8 with the checksum feature. It wraps to 0 on DONE.
- All outputs are registered; tx_o is glitch-free.

Optional Feature:
DEBUG_TX_CHECKSUM_EN
- Defined: a ninth byte follows p7. It is the XOR of p1..p7 (header excluded), computed from the snapshot. The frame is 90*CLKS_PER_BIT cycles and the byte index runs 0..8.
- Undefined: 8-byte frame, no checksum logic synthesised.

Decomposition:
- A shared package or include holds: the FSM state encoding (IDLE, START, DATA, STOP, DONE), the default HEADER_BYTE, UART framing constants (BITS_PER_BYTE=8, FRAME_BITS=10), and frame-length constants for both feature settings.
- One natural sub-module, uart_tx_byte. It takes a byte, start, and CLKS_PER_BIT, and returns done and tx. debug_uart_tx then reduces to the snapshot register, the byte sequencer and the optional checksum.

Test Plan:
1. CLKS_PER_BIT=4, ports=01,02,...,07, pulse send_i -> tx_o decodes A5 01 02 03 04 05 06 07 LSB-first. busy_o is high for exactly 320 cycles, then frame_done_o is a single pulse.
2. Snapshot isolation: accept with port1_i=3C, change port1_i to FF on the next cycle -> byte 1 on the line is 3C.
3. send_i held high continuously -> consecutive frames separated by exactly one idle-high cycle. A second send_i pulse mid-frame produces no extra frame.
4. nreset_i low at cycle 100 of a frame -> tx_o=1 and busy_o=0 immediately (asynchronously). After release, a new send_i yields a full correct frame.
5. DEBUG_TX_CHECKSUM_EN defined, ports=FF,00,00,00,00,00,01 -> 9 bytes A5 FF 00 00 00 00 00 01 FE. busy_o is high 360 cycles at CLKS_PER_BIT=4.
6. Bit timing: CLKS_PER_BIT=2 -> every tx_o level holds exactly 2 cycles. Start-bit low begins one cycle after the accept edge.
